mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles a grant may wait for s_ready before forced completion (timeout build only).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_valid/m1_valid, input, 1 each: master request, held until the matching ready (m0 = core, m1 = DMA/debug).
REQ-006 SHALL have ports m0_addr/m1_addr, m0_wdata/m1_wdata, input, 32 each; m0_wstrb/m1_wstrb, input, 4 each (wstrb 0 = read).
REQ-007 SHALL have ports m0_ready/m1_ready, output, 1 each; m0_rdata/m1_rdata, output, 32 each.
REQ-008 SHALL have ports s_valid output 1, s_addr output 32, s_wdata output 32, s_wstrb output 4, s_ready input 1, s_rdata input 32: downstream native bus toward the address decoder.
REQ-009 SHALL have port timeout_err, output, 1: one-cycle pulse on forced completion.

Function
REQ-010 SHALL implement states IDLE, GNT0, GNT1, plus a 1-bit last-grant register.
REQ-011 IDLE: a single requester is granted; with both requesting, the master not granted last wins; the state register updates at the next edge.
REQ-012 In GNTx: s_valid = mx_valid; s_addr/s_wdata/s_wstrb = master x fields. In IDLE: s_valid = 0 and s_addr/s_wdata/s_wstrb = 0.
REQ-013 In GNTx: mx_ready = s_ready && mx_valid, mx_rdata = s_rdata, combinational. The other master sees ready 0 and rdata 0.
REQ-014 In GNTx with s_ready && mx_valid: transfer complete; last-grant := x; next state IDLE.
REQ-015 Latency: valid first seen in IDLE at cycle n gives s_valid at n+1; a zero-wait slave completes at n+1. Back-to-back grants have exactly one IDLE bubble.
REQ-016 Round-robin: with both masters requesting continuously, grants SHALL alternate m0,m1,m0,...; no master waits more than one other transfer.
REQ-017 In GNTx with mx_valid deasserted (protocol abort): next state IDLE, last-grant unchanged, no ready issued.
REQ-018 A request from the non-granted master during GNTx SHALL be held off (ready 0) until arbitration in IDLE.
REQ-019 s_ready while in IDLE SHALL be ignored.

Reset
REQ-020 resetn low SHALL asynchronously force: state IDLE, last-grant = m1 (so m0 wins the first tie), timeout counter 0.
REQ-021 While in reset, all outputs SHALL be 0: m*_ready, m*_rdata, s_valid, s_addr, s_wdata, s_wstrb, timeout_err.
REQ-022 Reset mid-transfer SHALL abandon the transfer with no ready pulse; operation resumes in IDLE after deassertion.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: a counter clears on entry to GNTx and increments each GNTx cycle without s_ready. When it reaches TIMEOUT_CYCLES, that cycle SHALL drive mx_ready = 1, mx_rdata = ERR_RDATA, s_valid = 0 and timeout_err = 1; next state IDLE; last-grant := x.
REQ-024 Macro ARB_TIMEOUT_EN undefined: no counter logic; timeout_err tied 0; a grant waits indefinitely for s_ready.

Verification
REQ-025 m0 read 0x0000_0100, slave ready 1 cycle after s_valid with rdata 0x1234_5678 -> s_valid at n+1, m0_ready pulse at n+2 with m0_rdata 0x1234_5678, m1_ready stays 0.
REQ-026 m0 and m1 both valid at the same cycle after reset, zero-wait slave -> m0 granted first, m1 second, one IDLE cycle between.
REQ-027 Both masters issue 4 back-to-back writes, wstrb 4'hF -> s_addr sequence alternates m0,m1,m0,m1,...; all 8 complete with data matching the issuing master.
REQ-028 resetn pulled low while in GNT1 with slave stalled -> all outputs 0 immediately, no m1_ready; after release a pending m0 is granted first.
REQ-029 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never ready, m1 read -> m1_ready = 1 with rdata 0xDEADBEEF and timeout_err pulse 8 cycles after grant. Same stimulus without the macro -> no m1_ready and timeout_err stays 0.
REQ-030 m0 drops valid in GNT0 before s_ready -> IDLE next cycle, no m0_ready, m1 granted if requesting.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a single native memory bus (m0 = core, m1 = DMA/debug).
// Define ARB_TIMEOUT_EN to force completion of grants the slave never acknowledges.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero in IDLE so every grant starts counting from its first cycle; saturates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!s_ready && wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_MAX) &&
                       ((state == GNT0 && m0_valid) || (state == GNT1 && m1_valid));
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  // last_gnt = 1 means m1 was served last, so m0 wins the next tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last_gnt)) begin
            state <= GNT0;
          end else if (m1_valid) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_valid) begin
            state <= IDLE;
          end else if (s_ready || timeout_hit) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_valid) begin
            state <= IDLE;
          end else if (s_ready || timeout_hit) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A forced completion hides the request from the slave and answers the master itself.
  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    timeout_err = 1'b0;
    case (state)
      GNT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        if (timeout_hit) begin
          m0_ready    = 1'b1;
          m0_rdata    = ERR_RDATA;
          timeout_err = 1'b1;
        end else begin
          s_valid  = m0_valid;
          m0_ready = s_ready && m0_valid;
          m0_rdata = s_rdata;
        end
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        if (timeout_hit) begin
          m1_ready    = 1'b1;
          m1_rdata    = ERR_RDATA;
          timeout_err = 1'b1;
        end else begin
          s_valid  = m1_valid;
          m1_ready = s_ready && m1_valid;
          m1_rdata = s_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table plus hand sequences for tie, round-robin,
// reset-mid-grant and timeout (behaviour follows whether ARB_TIMEOUT_EN is defined).
module tb_mem_bus_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0v;
    logic [31:0] m0a;
    logic [31:0] m0d;
    logic [3:0]  m0s;
    logic        m1v;
    logic [31:0] m1a;
    logic [31:0] m1d;
    logic [3:0]  m1s;
    logic        sr;
    logic [31:0] srd;
    logic        e_m0r;
    logic [31:0] e_m0rd;
    logic        e_m1r;
    logic [31:0] e_m1rd;
    logic        e_sv;
    logic [31:0] e_sa;
    logic [31:0] e_sd;
    logic [3:0]  e_ss;
    logic        e_terr;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".m0_ready"}, 32'(m0_ready), 32'd0);
    checkOutput({tag, ".m0_rdata"}, m0_rdata, 32'd0);
    checkOutput({tag, ".m1_ready"}, 32'(m1_ready), 32'd0);
    checkOutput({tag, ".m1_rdata"}, m1_rdata, 32'd0);
    checkOutput({tag, ".s_valid"}, 32'(s_valid), 32'd0);
    checkOutput({tag, ".s_addr"}, s_addr, 32'd0);
    checkOutput({tag, ".s_wdata"}, s_wdata, 32'd0);
    checkOutput({tag, ".s_wstrb"}, 32'(s_wstrb), 32'd0);
    checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic clearInputs();
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready  = 0; s_rdata = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Drive one table row at the falling edge and compare the combinational outputs 1ns later.
  task automatic applyStimulus(input int idx, input vec_t v);
    string t;
    @(negedge clk);
    m0_valid = v.m0v; m0_addr = v.m0a; m0_wdata = v.m0d; m0_wstrb = v.m0s;
    m1_valid = v.m1v; m1_addr = v.m1a; m1_wdata = v.m1d; m1_wstrb = v.m1s;
    s_ready  = v.sr;  s_rdata = v.srd;
    #1;
    t = $sformatf("vec%0d", idx);
    checkOutput({t, ".m0_ready"}, 32'(m0_ready), 32'(v.e_m0r));
    checkOutput({t, ".m0_rdata"}, m0_rdata, v.e_m0rd);
    checkOutput({t, ".m1_ready"}, 32'(m1_ready), 32'(v.e_m1r));
    checkOutput({t, ".m1_rdata"}, m1_rdata, v.e_m1rd);
    checkOutput({t, ".s_valid"}, 32'(s_valid), 32'(v.e_sv));
    checkOutput({t, ".s_addr"}, s_addr, v.e_sa);
    checkOutput({t, ".s_wdata"}, s_wdata, v.e_sd);
    checkOutput({t, ".s_wstrb"}, 32'(s_wstrb), 32'(v.e_ss));
    checkOutput({t, ".timeout_err"}, 32'(timeout_err), 32'(v.e_terr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done;
    int steps;
    int i0;
    int i1;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;

    resetn = 1'b0;
    clearInputs();
    #1;
    checkIdle("in_reset");

    // Cycle table starting from IDLE with m0 winning the first tie.
    //          m0v m0a          m0d           m0s   m1v m1a          m1d           m1s   sr srd
    //          e_m0r e_m0rd     e_m1r e_m1rd  e_sv e_sa           e_sd          e_ss  e_terr
    vecs[0]  = '{0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   32'h0,         4'h0, 1, 32'h55,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[1]  = '{1, 32'h100, 32'h0,         4'h0, 0, 32'h0,   32'h0,         4'h0, 0, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[2]  = '{1, 32'h100, 32'h0,         4'h0, 1, 32'h200, 32'hA5A5_A5A5, 4'hF, 0, 32'h1111,
                 0, 32'h1111,      0, 32'h0,         1, 32'h100, 32'h0,         4'h0, 0};
    vecs[3]  = '{1, 32'h100, 32'h0,         4'h0, 1, 32'h200, 32'hA5A5_A5A5, 4'hF, 1, 32'h1234_5678,
                 1, 32'h1234_5678, 0, 32'h0,         1, 32'h100, 32'h0,         4'h0, 0};
    vecs[4]  = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h200, 32'hA5A5_A5A5, 4'hF, 1, 32'h9999,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[5]  = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h200, 32'hA5A5_A5A5, 4'hF, 1, 32'h77,
                 0, 32'h0,         1, 32'h77,        1, 32'h200, 32'hA5A5_A5A5, 4'hF, 0};
    vecs[6]  = '{1, 32'h300, 32'h0,         4'h0, 1, 32'h400, 32'h0,         4'h0, 1, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[7]  = '{1, 32'h300, 32'h0,         4'h0, 1, 32'h400, 32'h0,         4'h0, 1, 32'hAAAA_0000,
                 1, 32'hAAAA_0000, 0, 32'h0,         1, 32'h300, 32'h0,         4'h0, 0};
    vecs[8]  = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h400, 32'h0,         4'h0, 1, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[9]  = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h400, 32'h0,         4'h0, 1, 32'hBBBB_0000,
                 0, 32'h0,         1, 32'hBBBB_0000, 1, 32'h400, 32'h0,         4'h0, 0};
    vecs[10] = '{1, 32'h500, 32'hC0FF_EE00, 4'h3, 1, 32'h600, 32'h0,         4'h0, 0, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[11] = '{1, 32'h500, 32'hC0FF_EE00, 4'h3, 1, 32'h600, 32'h0,         4'h0, 0, 32'h0,
                 0, 32'h0,         0, 32'h0,         1, 32'h500, 32'hC0FF_EE00, 4'h3, 0};
    vecs[12] = '{0, 32'h500, 32'hC0FF_EE00, 4'h3, 1, 32'h600, 32'h0,         4'h0, 1, 32'hCC,
                 0, 32'hCC,        0, 32'h0,         0, 32'h500, 32'hC0FF_EE00, 4'h3, 0};
    vecs[13] = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h600, 32'h0,         4'h0, 0, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};
    vecs[14] = '{0, 32'h0,   32'h0,         4'h0, 1, 32'h600, 32'h0,         4'h0, 1, 32'h66,
                 0, 32'h0,         1, 32'h66,        1, 32'h600, 32'h0,         4'h0, 0};
    vecs[15] = '{0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   32'h0,         4'h0, 0, 32'h0,
                 0, 32'h0,         0, 32'h0,         0, 32'h0,   32'h0,         4'h0, 0};

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Simultaneous requests straight out of reset: m0, one IDLE bubble, then m1.
    doReset();
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
    s_ready = 1; s_rdata = 32'h42;
    #1;
    checkOutput("tie.c0.s_valid", 32'(s_valid), 32'd0);
    @(negedge clk); #1;
    checkOutput("tie.c1.m0_ready", 32'(m0_ready), 32'd1);
    checkOutput("tie.c1.m1_ready", 32'(m1_ready), 32'd0);
    checkOutput("tie.c1.s_addr", s_addr, 32'h10);
    @(negedge clk);
    m0_valid = 0; m0_addr = 0;
    #1;
    checkOutput("tie.c2.s_valid", 32'(s_valid), 32'd0);
    checkOutput("tie.c2.m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk); #1;
    checkOutput("tie.c3.m1_ready", 32'(m1_ready), 32'd1);
    checkOutput("tie.c3.s_addr", s_addr, 32'h20);
    checkOutput("tie.c3.m1_rdata", m1_rdata, 32'h42);

    // Four back-to-back writes per master into a zero-wait slave must strictly alternate.
    doReset();
    done = 0; steps = 0; i0 = 0; i1 = 0;
    while (done < 8 && steps < 40) begin
      @(negedge clk);
      m0_valid = (i0 < 4);
      m0_addr  = (i0 < 4) ? 32'h1000 + 32'(4 * i0) : 32'h0;
      m0_wdata = (i0 < 4) ? 32'hA000_0000 + 32'(i0) : 32'h0;
      m0_wstrb = (i0 < 4) ? 4'hF : 4'h0;
      m1_valid = (i1 < 4);
      m1_addr  = (i1 < 4) ? 32'h2000 + 32'(4 * i1) : 32'h0;
      m1_wdata = (i1 < 4) ? 32'hB000_0000 + 32'(i1) : 32'h0;
      m1_wstrb = (i1 < 4) ? 4'hF : 4'h0;
      s_ready  = 1; s_rdata = 32'h0;
      #1;
      if (m0_ready || m1_ready) begin
        exp_addr = (done % 2 == 0) ? 32'h1000 + 32'(4 * (done / 2)) : 32'h2000 + 32'(4 * (done / 2));
        exp_data = (done % 2 == 0) ? 32'hA000_0000 + 32'(done / 2) : 32'hB000_0000 + 32'(done / 2);
        checkOutput($sformatf("rr%0d.m1_ready", done), 32'(m1_ready), 32'(done % 2));
        checkOutput($sformatf("rr%0d.m0_ready", done), 32'(m0_ready), 32'(1 - done % 2));
        checkOutput($sformatf("rr%0d.s_addr", done), s_addr, exp_addr);
        checkOutput($sformatf("rr%0d.s_wdata", done), s_wdata, exp_data);
        checkOutput($sformatf("rr%0d.s_wstrb", done), 32'(s_wstrb), 32'hF);
        if (m0_ready) i0++;
        if (m1_ready) i1++;
        done++;
      end
      steps++;
    end
    checkOutput("rr.completions", 32'(done), 32'd8);
    checkOutput("rr.cycles", 32'(steps), 32'd16);

    // Reset asserted mid-grant to a stalled slave, with m0 queued behind m1.
    doReset();
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h4000; s_ready = 0; s_rdata = 32'h99;
    #1;
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h5000;
    #1;
    checkOutput("rst.gnt1.s_valid", 32'(s_valid), 32'd1);
    checkOutput("rst.gnt1.s_addr", s_addr, 32'h4000);
    checkOutput("rst.gnt1.m1_rdata", m1_rdata, 32'h99);
    #2;
    resetn = 1'b0;
    #1;
    checkIdle("rst.async");
    @(posedge clk); #1;
    checkIdle("rst.held");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkIdle("rst.release");
    @(negedge clk); #1;
    checkOutput("rst.regrant.s_valid", 32'(s_valid), 32'd1);
    checkOutput("rst.regrant.s_addr", s_addr, 32'h5000);
    checkOutput("rst.regrant.m1_ready", 32'(m1_ready), 32'd0);

    // m1 read against a slave that never answers.
    doReset();
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h3000; s_ready = 0; s_rdata = 32'h1357;
    #1;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k <= int'(TIMEOUT); k++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("to.k%0d.m1_ready", k), 32'(m1_ready), 32'(k == int'(TIMEOUT)));
      checkOutput($sformatf("to.k%0d.timeout_err", k), 32'(timeout_err), 32'(k == int'(TIMEOUT)));
      checkOutput($sformatf("to.k%0d.s_valid", k), 32'(s_valid), 32'(k != int'(TIMEOUT)));
      checkOutput($sformatf("to.k%0d.m1_rdata", k), m1_rdata,
                  (k == int'(TIMEOUT)) ? 32'hDEAD_BEEF : 32'h1357);
    end
    @(negedge clk);
    m1_valid = 0;
    #1;
    checkIdle("to.after");
`else
    for (int k = 0; k < int'(TIMEOUT) + 4; k++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("nto.k%0d.m1_ready", k), 32'(m1_ready), 32'd0);
      checkOutput($sformatf("nto.k%0d.timeout_err", k), 32'(timeout_err), 32'd0);
      checkOutput($sformatf("nto.k%0d.s_valid", k), 32'(s_valid), 32'd1);
    end
    @(negedge clk);
    m1_valid = 0;
    #1;
    checkOutput("nto.abort.m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk); #1;
    checkIdle("nto.after");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
